// File: rtl/z80_bus_pkg.sv
// z80_bus_pkg: shared types and constants for Z80 bus masters
package z80_bus_pkg;
  localparam int ADDR_W = 16;
  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;
  typedef enum logic [2:0] {IDLE, REQ, RD_A, RD_B, WR_A, WR_B, REL, GAP} dmaState;
endpackage

// File: rtl/dma_bus_drv.sv
// dma_bus_drv: tristate drivers for the Z80 bus, enabled only while the DMA owns it
module dma_bus_drv import z80_bus_pkg::*; (
  input  logic              ownBus,
  input  logic              dqWe,
  input  logic [ADDR_W-1:0] addr,
  input  logic              mreqN,
  input  logic              rdN,
  input  logic              wrN,
  input  logic [7:0]        dqOut,
  output logic [7:0]        dqIn,
  output logic [ADDR_W-1:0] ADDR,
  output logic              nMREQ,
  output logic              nRD,
  output logic              nWR,
  inout  wire  [7:0]        DQ
);
  assign ADDR  = ownBus ? addr : 'z;
  assign nMREQ = ownBus ? mreqN : 1'bz;
  assign nRD   = ownBus ? rdN : 1'bz;
  assign nWR   = ownBus ? wrN : 1'bz;
  assign DQ    = ownBus && dqWe ? dqOut : 'z;
  assign dqIn  = DQ;
endmodule

// File: rtl/dma_bus_master.sv
// dma_bus_master: Z80 bus-request DMA engine doing burst-limited copies and fills
module dma_bus_master import z80_bus_pkg::*; #(
  parameter int BURST_LEN  = 16,
  parameter int GAP_CYCLES = 4
) (
  input  logic              CLK,
  input  logic              nCLR,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [15:0]       len,
  input  logic [7:0]        fill_val,
  output logic              busy,
  output logic              done,
  output logic              nBUSRQ,
  input  logic              nBUSAK,
  output logic [ADDR_W-1:0] ADDR,
  inout  wire  [7:0]        DQ,
  output logic              nMREQ,
  output logic              nRD,
  output logic              nWR
);
  localparam int BW = $clog2(BURST_LEN + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  dmaState state, next;
  logic [ADDR_W-1:0] srcAddr, dstAddr;
  logic [15:0] remaining;
  logic [BW-1:0] burstCnt;
  logic [GW-1:0] gapCnt;
  logic [7:0] dataReg, dqIn;
  logic fillMode, finishing, lastByte, burstFull, ownBus, reading;
  assign lastByte  = remaining == 16'd1;
  assign burstFull = burstCnt == BW'(BURST_LEN - 1);
  assign reading   = state inside {RD_A, RD_B};
  assign ownBus    = state inside {RD_A, RD_B, WR_A, WR_B};
  assign busy      = state != IDLE;
  assign nBUSRQ    = !(state == REQ || ownBus);
  always_comb begin
    next = state;
    case (state)
      IDLE: next = start && len != '0 ? REQ : IDLE;
      REQ:  next = nBUSAK ? REQ : fillMode ? WR_A : RD_A;
      RD_A: next = RD_B;
      RD_B: next = WR_A;
      WR_A: next = WR_B;
      WR_B: next = lastByte || burstFull ? REL : fillMode ? WR_A : RD_A;
      REL:  next = !nBUSAK ? REL : finishing ? IDLE : GAP;
      GAP:  next = gapCnt == GW'(GAP_CYCLES - 1) ? REQ : GAP;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge nCLR) begin
    if (!nCLR) begin
      state     <= IDLE;
      srcAddr   <= '0;
      dstAddr   <= '0;
      remaining <= '0;
      burstCnt  <= '0;
      gapCnt    <= '0;
      dataReg   <= '0;
      fillMode  <= MODE_COPY;
      finishing <= 1'b0;
      done      <= 1'b0;
    end else begin
      state  <= next;
      done   <= (state == IDLE && start && len == '0) || (state == REL && nBUSAK && finishing);
      gapCnt <= state == GAP ? gapCnt + 1'b1 : '0;
      if (state == IDLE && start) begin
        srcAddr   <= src;
        dstAddr   <= dst;
        remaining <= len;
        fillMode  <= mode;
        dataReg   <= fill_val;
        finishing <= 1'b0;
        burstCnt  <= '0;
      end
      if (state == RD_B) dataReg <= dqIn;
      if (state == WR_B) begin
        srcAddr   <= fillMode == MODE_FILL ? srcAddr : srcAddr + 1'b1;
        dstAddr   <= dstAddr + 1'b1;
        remaining <= remaining - 1'b1;
        burstCnt  <= burstFull ? '0 : burstCnt + 1'b1;
        finishing <= lastByte;
      end
    end
  end
  dma_bus_drv drv (
    .ownBus(ownBus),
    .dqWe  (state inside {WR_A, WR_B}),
    .addr  (reading ? srcAddr : dstAddr),
    .mreqN (1'b0),
    .rdN   (!reading),
    .wrN   (state != WR_B),
    .dqOut (dataReg),
    .dqIn  (dqIn),
    .ADDR  (ADDR),
    .nMREQ (nMREQ),
    .nRD   (nRD),
    .nWR   (nWR),
    .DQ    (DQ)
  );
endmodule
